// File: rtl/mxrv_if_pkg.sv
// -----------------------------------------------------------------------------
// mxrv_if_pkg
// Shared definitions for the mxrv instruction fetch stage: word width, the
// NOP presented to decode when nothing is buffered, the default reset PC,
// the fetch-buffer entry layout and a word-alignment helper.
// -----------------------------------------------------------------------------
package mxrv_if_pkg;

   localparam int PORT_WORD_WIDTH = 32;

   typedef logic [PORT_WORD_WIDTH-1:0] word_t;

   localparam word_t INST_NOP         = 32'h0000_0013;  // addi x0, x0, 0
   localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;

   // One buffered instruction together with the PC it was fetched from.
   typedef struct packed {
      word_t addr;
      word_t data;
   } fetch_entry_t;

   // Clears the byte offset so every fetch address is word aligned.
   function automatic word_t word_align(input word_t a);
      return {a[PORT_WORD_WIDTH-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/mxrv_if_if.sv
// -----------------------------------------------------------------------------
// mxrv_if_if
// Instruction-memory request/response bus.
//   req    : fetch request valid            (core -> memory)
//   addr   : word-aligned fetch address     (core -> memory)
//   gnt    : request accepted this cycle    (memory -> core)
//   rvalid : read data valid, in order      (memory -> core)
//   rdata  : fetched instruction word       (memory -> core)
// The fetch stage uses the master modport; the memory uses the slave modport.
// -----------------------------------------------------------------------------
interface mxrv_if_if;
   import mxrv_if_pkg::*;

   logic  req;
   word_t addr;
   logic  gnt;
   logic  rvalid;
   word_t rdata;

   modport master (output req, addr, input gnt, rvalid, rdata);
   modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/mxrv_if_fifo.sv
// -----------------------------------------------------------------------------
// mxrv_if_fifo
// Small synchronous FIFO with flush. The head is read combinationally from
// the storage array, so a word pushed at an edge is visible the next cycle.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : empty the FIFO at the next edge (wins over push/pop)
//   push, push_data : write an entry
//   pop        : drop the head entry (ignored when empty)
//   head       : current head entry (undefined when empty)
//   full, empty, count : occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module mxrv_if_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef logic [CW-1:0] cnt_t;
   typedef logic [AW-1:0] ptr_t;

   logic [WIDTH-1:0] mem [DEPTH];
   ptr_t wr_ptr;
   ptr_t rd_ptr;
   logic do_push;
   logic do_pop;

   assign full  = (count == cnt_t'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   // A push into a full FIFO is only accepted when the head leaves the same cycle.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of every other flop, independent of block order.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + cnt_t'(do_push) - cnt_t'(do_pop);
      end
   end

   // NOTE: storage has no reset; the pointers and count alone define which
   // entries are valid, and leaving the array unreset keeps it a plain RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   a_no_overflow : assert property (@(posedge clk) disable iff (rst)
      !(push && full && !pop && !flush));

endmodule

// File: rtl/mxrv_if.sv
// -----------------------------------------------------------------------------
// mxrv_if
// Instruction fetch stage of the mxrv core.
//   clk, rst      : core clock, synchronous active-high reset
//   imem          : instruction-memory bus (req/addr/gnt/rvalid/rdata)
//   jump_flag_i   : redirect from execute; jump_addr_i is the target
//   hold_i        : pipeline hold, blocks new requests only
//   inst_valid_o, inst_ready_i : handshake towards decode
//   inst_data_o, inst_addr_o   : head instruction and its PC (NOP/0 when empty)
// Fetches are issued against a credit: requests in flight, words buffered and
// stale responses still to be dropped together never exceed FIFO_DEPTH, so the
// buffer can never overflow. A shadow queue remembers the PC of each granted
// request so responses can be tagged with their address in order.
// -----------------------------------------------------------------------------
module mxrv_if
   import mxrv_if_pkg::*;
#(
   parameter word_t RESET_PC   = RESET_PC_DEFAULT,
   parameter int    FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   mxrv_if_if.master         imem,
   input  logic              jump_flag_i,
   input  word_t             jump_addr_i,
   input  logic              hold_i,
   output logic              inst_valid_o,
   input  logic              inst_ready_i,
   output word_t             inst_data_o,
   output word_t             inst_addr_o
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   typedef logic [CW-1:0] cnt_t;
   typedef logic [CW+1:0] sum_t;  // three counters each <= FIFO_DEPTH

   word_t pc_q;
   cnt_t  outstanding_q;
   cnt_t  discard_q;

   logic  may_issue;
   logic  granted;
   logic  drop_resp;
   logic  keep_resp;
   sum_t  credit_used;

   // Shadow address queue: PC of every granted request not yet answered.
   word_t shadow_pc;
   logic  shadow_full;
   logic  shadow_empty;
   cnt_t  shadow_count;

   // Fetch buffer towards decode.
   fetch_entry_t buf_push_data;
   fetch_entry_t buf_head;
   logic         buf_full;
   logic         buf_empty;
   cnt_t         buf_count;
   logic         buf_pop;

   // NOTE: every signal assigned in always_comb gets a default first so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      credit_used = '0;
      may_issue   = 1'b0;
      granted     = 1'b0;
      drop_resp   = 1'b0;
      keep_resp   = 1'b0;

      credit_used = sum_t'(outstanding_q) + sum_t'(buf_count) + sum_t'(discard_q);
      may_issue   = !rst && !hold_i && !jump_flag_i && (credit_used < sum_t'(FIFO_DEPTH));
      granted     = may_issue && imem.gnt;
      drop_resp   = imem.rvalid && (discard_q != '0);
      // In the redirect cycle a live response is stale too; the discard
      // update below already accounts for it.
      keep_resp   = imem.rvalid && (discard_q == '0) && !jump_flag_i;
   end

   assign imem.req  = may_issue;
   assign imem.addr = pc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= word_align(RESET_PC);
         outstanding_q <= '0;
         discard_q     <= '0;
      end else if (jump_flag_i) begin
         pc_q          <= word_align(jump_addr_i);
         outstanding_q <= '0;
         // Everything still owed by memory becomes stale; repeated redirects accumulate.
         discard_q     <= discard_q + outstanding_q + cnt_t'(granted) - cnt_t'(imem.rvalid);
      end else begin
         if (granted) pc_q <= pc_q + 32'd4;
         outstanding_q <= outstanding_q + cnt_t'(granted) - cnt_t'(keep_resp);
         if (drop_resp) discard_q <= discard_q - 1'b1;
      end
   end

   mxrv_if_fifo #(
      .WIDTH (PORT_WORD_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_shadow_q (
      .clk       (clk),
      .rst       (rst),
      .flush     (jump_flag_i),
      .push      (granted),
      .push_data (pc_q),
      .pop       (keep_resp),
      .head      (shadow_pc),
      .full      (shadow_full),
      .empty     (shadow_empty),
      .count     (shadow_count)
   );

   assign buf_push_data = '{addr: shadow_pc, data: imem.rdata};
   assign buf_pop       = inst_ready_i && inst_valid_o;

   mxrv_if_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fetch_buf (
      .clk       (clk),
      .rst       (rst),
      .flush     (jump_flag_i),
      .push      (keep_resp),
      .push_data (buf_push_data),
      .pop       (buf_pop),
      .head      (buf_head),
      .full      (buf_full),
      .empty     (buf_empty),
      .count     (buf_count)
   );

   assign inst_valid_o = !buf_empty;
   assign inst_data_o  = buf_empty ? INST_NOP : buf_head.data;
   assign inst_addr_o  = buf_empty ? '0       : buf_head.addr;

   // The shadow queue tracks exactly the requests still in flight.
   a_shadow_tracks : assert property (@(posedge clk) disable iff (rst)
      shadow_count == outstanding_q);
   a_resp_has_pc   : assert property (@(posedge clk) disable iff (rst)
      keep_resp |-> !shadow_empty);
   a_shadow_room   : assert property (@(posedge clk) disable iff (rst)
      granted |-> (!shadow_full || keep_resp));
   a_buf_room      : assert property (@(posedge clk) disable iff (rst)
      keep_resp |-> (!buf_full || buf_pop));

endmodule

// File: tb/tb_mxrv_if.sv
// -----------------------------------------------------------------------------
// tb_mxrv_if
// Bench for the mxrv fetch stage. A memory model answers granted requests in
// order (earliest one cycle after gnt) with a word derived from the address.
// Every grant pushes the expected {addr, data} onto a scoreboard queue; every
// decode handshake pops and compares it. A redirect empties the expected queue,
// so any stale response reaching decode shows up as a mismatch.
// -----------------------------------------------------------------------------
module tb_mxrv_if;
   import mxrv_if_pkg::*;

   localparam int DEPTH = 2;

   logic  clk = 1'b0;
   logic  rst;
   logic  jump_flag;
   word_t jump_addr;
   logic  hold;
   logic  inst_valid;
   logic  inst_ready;
   word_t inst_data;
   word_t inst_addr;

   always #5 clk = ~clk;

   mxrv_if_if imem ();

   mxrv_if #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .imem         (imem),
      .jump_flag_i  (jump_flag),
      .jump_addr_i  (jump_addr),
      .hold_i       (hold),
      .inst_valid_o (inst_valid),
      .inst_ready_i (inst_ready),
      .inst_data_o  (inst_data),
      .inst_addr_o  (inst_addr)
   );

   int checks = 0;
   int errors = 0;

   word_t        mem_q[$];      // granted addresses awaiting a response
   fetch_entry_t exp_q[$];      // scoreboard of instructions decode should see
   word_t        grant_log[$];  // granted addresses since the last clear
   word_t        pop_log[$];    // addresses consumed by decode since the last clear

   int   gnt_stall = 0;         // cycles the memory withholds gnt
   logic rvalid_en = 1'b1;      // memory may return responses

   function automatic word_t mem_word(input word_t a);
      return a ^ 32'h5A5A_0F0F;
   endfunction

   // Memory model: drives gnt/rvalid/rdata shortly after each rising edge.
   initial begin
      imem.gnt    = 1'b0;
      imem.rvalid = 1'b0;
      imem.rdata  = '0;
      forever begin
         @(posedge clk);
         #2;
         if (rst) begin
            imem.rvalid = 1'b0;
            imem.gnt    = 1'b1;
         end else begin
            if (rvalid_en && mem_q.size() > 0) begin
               imem.rvalid = 1'b1;
               imem.rdata  = mem_word(mem_q.pop_front());
            end else begin
               imem.rvalid = 1'b0;
               imem.rdata  = '0;
            end
            if (gnt_stall > 0) begin
               imem.gnt  = 1'b0;
               gnt_stall = gnt_stall - 1;
            end else begin
               imem.gnt = 1'b1;
            end
         end
      end
   end

   // Scoreboard: samples mid-cycle, away from the active edge.
   initial begin : scoreboard
      fetch_entry_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            mem_q.delete();
            exp_q.delete();
         end else begin
            if (imem.req && imem.gnt) begin
               checks++;
               if (imem.addr[1:0] !== 2'b00) begin
                  errors++;
                  $display("FAIL sb_addr_align: addr=%h, expected bits[1:0]=00", imem.addr);
               end
               mem_q.push_back(imem.addr);
               exp_q.push_back('{addr: imem.addr, data: mem_word(imem.addr)});
               grant_log.push_back(imem.addr);
            end
            if (jump_flag) begin
               exp_q.delete();
            end else if (inst_valid && inst_ready) begin
               pop_log.push_back(inst_addr);
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL sb_unexpected: got addr=%h data=%h, expected no instruction",
                           inst_addr, inst_data);
               end else begin
                  e = exp_q.pop_front();
                  if (inst_addr !== e.addr || inst_data !== e.data) begin
                     errors++;
                     $display("FAIL sb_pop: got addr=%h data=%h, expected addr=%h data=%h",
                              inst_addr, inst_data, e.addr, e.data);
                  end
               end
            end else if (!inst_valid) begin
               checks++;
               if (inst_data !== INST_NOP || inst_addr !== 32'h0) begin
                  errors++;
                  $display("FAIL sb_empty_out: data=%h addr=%h, expected data=%h addr=00000000",
                           inst_data, inst_addr, INST_NOP);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Holds reset for n edges, then releases it; returns inside the first
   // cycle after reset, where the first request is expected.
   task automatic do_reset(input int n);
      rst       = 1'b1;
      jump_flag = 1'b0;
      jump_addr = '0;
      hold      = 1'b0;
      repeat (n) tick();
      rst = 1'b0;
      grant_log.delete();
      pop_log.delete();
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      jump_flag  = 1'b0;
      jump_addr  = '0;
      hold       = 1'b0;
      inst_ready = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      checks++;
      if (imem.req !== 1'b0 || inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: req=%b valid=%b, expected req=0 valid=0", imem.req, inst_valid);
      end
      checks++;
      if (inst_data !== INST_NOP || inst_addr !== 32'h0) begin
         errors++;
         $display("FAIL reset_out: data=%h addr=%h, expected data=%h addr=00000000",
                  inst_data, inst_addr, INST_NOP);
      end
   endtask

   task automatic test_stream();
      bit in_order;
      inst_ready = 1'b1;
      rvalid_en  = 1'b1;
      do_reset(2);
      @(negedge clk);
      checks++;
      if (imem.req !== 1'b1 || imem.addr !== 32'h0 || inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_c0: req=%b addr=%h valid=%b, expected req=1 addr=00000000 valid=0",
                  imem.req, imem.addr, inst_valid);
      end
      tick();
      @(negedge clk);
      checks++;
      if (imem.req !== 1'b1 || imem.addr !== 32'h4 || inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_c1: req=%b addr=%h valid=%b, expected req=1 addr=00000004 valid=0",
                  imem.req, imem.addr, inst_valid);
      end
      tick();
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b1 || inst_addr !== 32'h0) begin
         errors++;
         $display("FAIL stream_latency: valid=%b addr=%h, expected valid=1 addr=00000000",
                  inst_valid, inst_addr);
      end
      repeat (30) tick();
      checks++;
      if (grant_log.size() < 4 || grant_log[0] !== 32'h0 || grant_log[1] !== 32'h4 ||
          grant_log[2] !== 32'h8 || grant_log[3] !== 32'hC) begin
         errors++;
         $display("FAIL stream_grants: %0d grants, first=%h, expected 00000000,00000004,00000008,0000000c",
                  grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : 32'hx);
      end
      in_order = 1'b1;
      foreach (pop_log[i]) if (pop_log[i] !== word_t'(i * 4)) in_order = 1'b0;
      checks++;
      if (pop_log.size() < 15 || !in_order) begin
         errors++;
         $display("FAIL stream_progress: %0d pops in_order=%b, expected >=15 sequential pops",
                  pop_log.size(), in_order);
      end
   endtask

   task automatic test_backpressure();
      inst_ready = 1'b0;
      rvalid_en  = 1'b1;
      do_reset(2);
      repeat (10) tick();
      @(negedge clk);
      checks++;
      if (imem.req !== 1'b0 || inst_valid !== 1'b1 || inst_addr !== 32'h0) begin
         errors++;
         $display("FAIL bp_stalled: req=%b valid=%b addr=%h, expected req=0 valid=1 addr=00000000",
                  imem.req, inst_valid, inst_addr);
      end
      checks++;
      if (grant_log.size() != DEPTH) begin
         errors++;
         $display("FAIL bp_buffered: %0d fetches, expected %0d", grant_log.size(), DEPTH);
      end
      tick();
      inst_ready = 1'b1;
      repeat (10) tick();
      checks++;
      if (pop_log.size() < 3 || pop_log[0] !== 32'h0 || pop_log[1] !== 32'h4 ||
          pop_log[2] !== 32'h8 || grant_log.size() < 3 || grant_log[2] !== 32'h8) begin
         errors++;
         $display("FAIL bp_resume: %0d pops %0d grants, expected pops 0,4,8 and third grant 00000008",
                  pop_log.size(), grant_log.size());
      end
   endtask

   task automatic test_redirect();
      inst_ready = 1'b1;
      rvalid_en  = 1'b0;
      do_reset(2);
      repeat (3) tick();          // two fetches granted, responses held back
      jump_flag = 1'b1;
      jump_addr = 32'h0000_0102;
      @(negedge clk);
      checks++;
      if (imem.req !== 1'b0) begin
         errors++;
         $display("FAIL redir_req: req=%b in redirect cycle, expected 0", imem.req);
      end
      tick();
      jump_flag = 1'b0;
      rvalid_en = 1'b1;           // the two stale responses arrive now
      grant_log.delete();
      pop_log.delete();
      @(negedge clk);
      checks++;
      if (imem.addr !== 32'h100 || inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL redir_target: addr=%h valid=%b, expected addr=00000100 valid=0",
                  imem.addr, inst_valid);
      end
      repeat (10) tick();
      checks++;
      if (grant_log.size() < 1 || grant_log[0] !== 32'h100 ||
          pop_log.size() < 1 || pop_log[0] !== 32'h100) begin
         errors++;
         $display("FAIL redir_first: first grant=%h first pop=%h, expected 00000100 for both",
                  (grant_log.size() > 0) ? grant_log[0] : 32'hx,
                  (pop_log.size() > 0) ? pop_log[0] : 32'hx);
      end
   endtask

   task automatic test_gnt_stall();
      inst_ready = 1'b1;
      rvalid_en  = 1'b1;
      do_reset(2);
      gnt_stall = 3;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (imem.req !== 1'b1 || imem.addr !== 32'h0) begin
            errors++;
            $display("FAIL stall_hold_%0d: req=%b addr=%h, expected req=1 addr=00000000",
                     i, imem.req, imem.addr);
         end
         tick();
      end
      @(negedge clk);
      checks++;
      if (imem.addr !== 32'h4) begin
         errors++;
         $display("FAIL stall_advance: addr=%h, expected 00000004", imem.addr);
      end
      repeat (6) tick();
      checks++;
      if (grant_log.size() < 2 || grant_log[0] !== 32'h0 || grant_log[1] !== 32'h4) begin
         errors++;
         $display("FAIL stall_grants: %0d grants, expected 00000000 then 00000004", grant_log.size());
      end
   endtask

   task automatic test_hold();
      inst_ready = 1'b1;
      rvalid_en  = 1'b1;
      do_reset(2);                // fetch of 0x0 granted in this cycle
      tick();
      hold = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (imem.req !== 1'b0) begin
            errors++;
            $display("FAIL hold_req_%0d: req=%b, expected 0", i, imem.req);
         end
         tick();
      end
      checks++;
      if (pop_log.size() != 1 || pop_log[0] !== 32'h0) begin
         errors++;
         $display("FAIL hold_drain: %0d pops, expected one pop of 00000000", pop_log.size());
      end
      hold = 1'b0;
      repeat (6) tick();
      checks++;
      if (grant_log.size() < 2 || grant_log[1] !== 32'h4) begin
         errors++;
         $display("FAIL hold_resume: %0d grants, expected second grant 00000004", grant_log.size());
      end
   endtask

   task automatic test_wrap_and_reset();
      inst_ready = 1'b1;
      rvalid_en  = 1'b1;
      do_reset(2);
      repeat (4) tick();
      jump_flag = 1'b1;
      jump_addr = 32'hFFFF_FFFF;  // low bits ignored -> 0xFFFF_FFFC
      tick();
      jump_flag = 1'b0;
      grant_log.delete();
      pop_log.delete();
      repeat (10) tick();
      checks++;
      if (grant_log.size() < 2 || grant_log[0] !== 32'hFFFF_FFFC || grant_log[1] !== 32'h0) begin
         errors++;
         $display("FAIL wrap_grants: %0d grants, expected fffffffc then 00000000", grant_log.size());
      end
      checks++;
      if (pop_log.size() < 2 || pop_log[0] !== 32'hFFFF_FFFC || pop_log[1] !== 32'h0) begin
         errors++;
         $display("FAIL wrap_pops: %0d pops, expected fffffffc then 00000000", pop_log.size());
      end
      // Reset while fetches are outstanding.
      rvalid_en = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      tick();
      tick();
      @(negedge clk);
      checks++;
      if (imem.req !== 1'b0 || inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL midreset_out: req=%b valid=%b, expected req=0 valid=0", imem.req, inst_valid);
      end
      tick();
      rst       = 1'b0;
      rvalid_en = 1'b1;
      grant_log.delete();
      pop_log.delete();
      @(negedge clk);
      checks++;
      if (imem.req !== 1'b1 || imem.addr !== 32'h0) begin
         errors++;
         $display("FAIL midreset_first: req=%b addr=%h, expected req=1 addr=00000000",
                  imem.req, imem.addr);
      end
      repeat (8) tick();
      checks++;
      if (pop_log.size() < 1 || pop_log[0] !== 32'h0) begin
         errors++;
         $display("FAIL midreset_pop: %0d pops, expected first pop 00000000", pop_log.size());
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_gnt_stall();
      test_hold();
      test_wrap_and_reset();
      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mxrv_if.md
Name: mxrv_if

Overview:
Instruction fetch stage of the mxrv core, directly upstream of the decode stage.
- Owns the PC and issues word fetches to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words with their addresses in a small in-order FIFO.
- Presents the FIFO head to decode (inst_data_o feeds decode's inst_data_i) with valid/ready flow control.
- Handles redirects from execute (jump/branch) by flushing buffered and in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset.
FIFO_DEPTH, 2, fetch buffer entries; also the cap on (in-flight + buffered) fetches; power of two, ≥2.

Ports:
clk  in  1  core clock; all state updates on the rising edge.
rst  in  1  reset, synchronous, active-high.
imem_req_o  out  1  fetch request valid.
imem_addr_o  out  32  fetch address, word aligned (bits [1:0] always 0).
imem_gnt_i  in  1  request accepted this cycle when imem_req_o=1.
imem_rvalid_i  in  1  read data valid; responses return in request order, ≥1 cycle after gnt.
imem_rdata_i  in  32  fetched instruction word.
jump_flag_i  in  1  redirect request from execute.
jump_addr_i  in  32  redirect target; bits [1:0] ignored (treated as 0).
hold_i  in  1  global pipeline hold; blocks new requests only.
inst_valid_o  out  1  inst_data_o/inst_addr_o valid.
inst_ready_i  in  1  decode consumes the head entry when valid&ready.
inst_data_o  out  32  instruction to decode.
inst_addr_o  out  32  PC of inst_data_o.

Behaviour:
- Reset (rst=1 at an edge):
  - Internal state: pc=RESET_PC; FIFO empty; outstanding=0; discard=0.
  - Outputs: imem_req_o=0, inst_valid_o=0.
  - Reset has priority over every other input, including mid-transaction. Responses arriving after reset for pre-reset requests are the memory's responsibility; imem is reset together with the core.
- Credit: may_issue = !hold_i & !jump_flag_i & (outstanding + fifo_count + discard < FIFO_DEPTH).
- Request:
  - imem_req_o = may_issue; imem_addr_o = pc.
  - On req&gnt: pc += 4 (32-bit wrap, 0xFFFF_FFFC -> 0x0000_0000) and outstanding++.
  - Without gnt, pc holds and the request is repeated next cycle.
- First request: first cycle after rst deasserts.
- Response:
  - On rvalid with discard>0: discard--, data dropped.
  - Otherwise push {pc_of_request, rdata} and outstanding--.
  - Request PCs come from a shadow address queue of FIFO_DEPTH entries, pushed on gnt.
- Output:
  - FIFO is registered: inst_valid_o rises the cycle after the accepted rvalid.
  - Latency is 2 cycles from gnt to inst_valid_o with zero-wait memory.
  - When the FIFO is empty: inst_valid_o=0, inst_data_o=32'h0000_0013 (NOP), inst_addr_o=0.
- Simultaneous events: push and pop in the same cycle with the FIFO full is legal (count unchanged).
- Credit guarantees no push when full. A push while full is an assertion failure.
- Redirect (jump_flag_i=1 at an edge):
  - pc <= {jump_addr_i[31:2],2'b00}.
  - FIFO and shadow queue cleared.
  - discard <= outstanding + (req&gnt this cycle) − (rvalid this cycle).
  - outstanding <= 0.
  - imem_req_o=0 in the redirect cycle; an ungranted request is abandoned, which the core imem protocol permits.
  - Fetch from the target starts the next cycle.
  - inst_valid_o=0 the cycle after the redirect edge.
  - A pop in the redirect cycle is irrelevant.
  - Back-to-back redirects: the last one wins; discard accumulates.
- Hold:
  - hold_i blocks new requests only.
  - Outstanding responses still land in the FIFO.
  - The output handshake is unaffected. Decode applies hold via inst_ready_i.
- Counter widths: outstanding, discard, count are clog2(FIFO_DEPTH)+1 bits; they never exceed FIFO_DEPTH.

Decomposition:
- Shared header: PORT_WORD_WIDTH, INST_NOP (32'h0000_0013), RESET_PC default.
- Sub-module mxrv_if_fifo: synchronous FIFO with width/depth parameters, push/pop/flush, full/empty/count.
  - Instantiated twice: the data+addr buffer, and the shadow address queue.

Test Plan:
- Reset release, gnt tied 1, rvalid one cycle after gnt, ready=1 -> imem_addr_o 0x0,0x4,0x8…; first inst_valid_o 2 cycles after first gnt with inst_addr_o=0x0; then one instruction per cycle.
- ready=0 for 10 cycles -> exactly FIFO_DEPTH=2 words buffered, imem_req_o=0 afterward; release ready -> words 0x0,0x4 emitted in order, fetch resumes at 0x8.
- Redirect to 0x0000_0102 with 2 fetches in flight -> next imem_addr_o=0x100; both stale responses dropped; first inst_addr_o after redirect = 0x100.
- Memory stalls gnt for 3 cycles -> imem_req_o and imem_addr_o stable throughout; pc advances only on the granted cycle.
- hold_i=1 with one fetch outstanding -> no new req; outstanding word still appears on inst_data_o; resumes when hold_i=0.
- pc=0xFFFF_FFFC -> next request address 0x0000_0000; rst asserted while a fetch is outstanding -> next cycle outputs at reset values, first request at RESET_PC.
